// File: rtl/ram_bist_ctrl.sv
// BIST master for a single-port RAM: writes a pattern to every word, reads it back and tallies mismatches.
// Latency: 2049 busy cycles per run; backpressure: none, 1-cycle read data is always accepted.
module ram_bist_ctrl #(
    parameter int ADDR_SIZE = 10,
    parameter int WORD_SIZE = 8,
    parameter int MEM_SIZE  = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           pattern_sel,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic                 mem_wr,
    output logic                 mem_cs,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ADDR_SIZE:0]   err_count,
    output logic [ADDR_SIZE-1:0] first_err_addr
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_SIZE - 1);
    localparam logic [ADDR_SIZE:0]   ERR_MAX   = (ADDR_SIZE + 1)'(MEM_SIZE);

    state_t               state;
    logic [1:0]           pat;
    logic                 rd_vld;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 mismatch;

    function automatic logic [WORD_SIZE-1:0] pattern_of(input logic [1:0] sel,
                                                       input logic [ADDR_SIZE-1:0] k);
        logic [7:0] p;
        logic [7:0] k8;
        k8 = 8'(k);
        case (sel)
            2'd0:    p = 8'({k, 1'b0});
            2'd1:    p = k8 ^ 8'hA5;
            2'd2:    p = k8[0] ? 8'hAA : 8'h55;
            default: p = 8'hFF;
        endcase
        return WORD_SIZE'(p);
    endfunction

    // rd_addr trails mem_addr by one cycle, matching the RAM's read latency
    assign mismatch = rd_vld && (mem_rdata != pattern_of(pat, rd_addr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pat            <= 2'd0;
            rd_vld         <= 1'b0;
            rd_addr        <= '0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_wr         <= 1'b0;
            mem_cs         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            rd_vld <= 1'b0;
            if (mismatch) begin
                if (err_count != ERR_MAX)
                    err_count <= err_count + 1'b1;
                if (err_count == '0)
                    first_err_addr <= rd_addr;
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        pat            <= pattern_sel;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        pass           <= 1'b0;
                        done           <= 1'b0;
                        busy           <= 1'b1;
                        state          <= WRITE;
                        mem_addr       <= '0;
                        mem_cs         <= 1'b1;
                        mem_wr         <= 1'b1;
                        mem_wdata      <= pattern_of(pattern_sel, '0);
                    end
                end
                WRITE: begin
                    if (mem_addr == LAST_ADDR) begin
                        state     <= READ;
                        mem_addr  <= '0;
                        mem_wr    <= 1'b0;
                        mem_wdata <= '0;
                    end else begin
                        mem_addr  <= mem_addr + 1'b1;
                        mem_wdata <= pattern_of(pat, mem_addr + 1'b1);
                    end
                end
                READ: begin
                    rd_vld  <= 1'b1;
                    rd_addr <= mem_addr;
                    if (mem_addr == LAST_ADDR) begin
                        state    <= DRAIN;
                        mem_cs   <= 1'b0;
                        mem_addr <= '0;
                    end else begin
                        mem_addr <= mem_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_count == '0) && !mismatch;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl with a 1024x8 synchronous RAM model and injectable read faults.
module tb_ram_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wr;
    logic        mem_cs;
    logic [7:0]  mem_rdata = 8'h00;
    logic        busy;
    logic        done;
    logic        pass;
    logic [10:0] err_count;
    logic [9:0]  first_err_addr;

    logic [7:0]  mem [1024];
    int          fault_mode = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc;

    always #5 clk = ~clk;

    ram_bist_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern_sel(pattern_sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_cs(mem_cs),
        .mem_rdata(mem_rdata), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr)
    );

    // RAM model: write on edge, read data registered on edge; faults applied on the read path
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_wr) begin
                mem[mem_addr] <= mem_wdata;
            end else begin
                case (fault_mode)
                    1:       mem_rdata <= (mem_addr == 10'd5) ? (mem[mem_addr] | 8'h01) : mem[mem_addr];
                    2:       mem_rdata <= mem[mem_addr] & 8'h7F;
                    default: mem_rdata <= mem[mem_addr];
                endcase
            end
        end
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    task automatic run(input logic [1:0] sel, input int restart_at, output int cycles);
        @(negedge clk);
        pattern_sel = sel;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pattern_sel = 2'd0;
        cycles = 0;
        while (busy && cycles < 3000) begin
            cycles++;
            if (cycles == restart_at) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cs", mem_cs, 0);
        chk("rst_err", err_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // fault-free, pattern 0
        fault_mode = 0;
        run(2'd0, 0, cyc);
        chk("p0_cycles", cyc, 2049);
        chk("p0_done", done, 1);
        chk("p0_pass", pass, 1);
        chk("p0_err", err_count, 0);
        chk("p0_first", first_err_addr, 0);
        chk("p0_mem5", mem[5], 8'h0A);
        chk("p0_mem200", mem[200], 8'h90);
        repeat (5) @(negedge clk);
        chk("p0_done_held", done, 1);
        chk("p0_cs_idle", mem_cs, 0);

        // bit0 of address 5 stuck at 1
        fault_mode = 1;
        run(2'd0, 0, cyc);
        chk("sa1_done", done, 1);
        chk("sa1_pass", pass, 0);
        chk("sa1_err", err_count, 1);
        chk("sa1_first", first_err_addr, 5);

        // bit7 stuck at 0 everywhere, all-ones pattern: every word fails
        fault_mode = 2;
        run(2'd3, 0, cyc);
        chk("sa0_err", err_count, 1024);
        chk("sa0_first", first_err_addr, 0);
        chk("sa0_pass", pass, 0);

        // checkerboard with an ignored second start
        fault_mode = 0;
        run(2'd2, 100, cyc);
        chk("p2_cycles", cyc, 2049);
        chk("p2_mem0", mem[0], 8'h55);
        chk("p2_mem1", mem[1], 8'hAA);
        chk("p2_pass", pass, 1);

        // reset during READ at k=300
        @(negedge clk);
        pattern_sel = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(mem_cs && !mem_wr && mem_addr == 10'd300) && cyc < 3000) begin
            cyc++;
            @(negedge clk);
        end
        chk("rd300_reached", int'(cyc < 3000), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cs", mem_cs, 0);
        chk("mid_rst_wr", mem_wr, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_wdata", mem_wdata, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_pass", pass, 0);
        chk("mid_rst_err", err_count, 0);
        chk("mid_rst_first", first_err_addr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle_cs", mem_cs, 0);

        run(2'd1, 0, cyc);
        chk("p1_cycles", cyc, 2049);
        chk("p1_pass", pass, 1);
        chk("p1_mem0", mem[0], 8'hA5);
        chk("p1_mem1", mem[1], 8'hA4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
